// File: rtl/ram_nxw_sync.sv
// Single-port DEPTH x WIDTH RAM with a registered read (1-cycle latency), out-of-range flag and zero-fill sweep.
// No backpressure: accesses are accepted whenever idle and dropped while busy (sweep) is high.
module ram_nxw_sync #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             CLK_,
  input  logic             CLR,
  input  logic             EN_,
  input  logic             R_W_,
  input  logic [AW-1:0]    ADDR_,
  input  logic [WIDTH-1:0] data_in,
  input  logic             CLR_MEM,
  output logic [WIDTH-1:0] data_out,
  output logic             rd_valid,
  output logic             addr_err,
  output logic             busy
);

  typedef enum logic {IDLE, CLEAR} state_t;

  localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

  state_t           state, state_nxt;
  logic [AW-1:0]    ptr, ptr_nxt;
  logic             mem_we;
  logic [AW-1:0]    mem_wa;
  logic [WIDTH-1:0] mem_wd;
  logic             in_range;
  logic             accept;

  logic [WIDTH-1:0] mem [DEPTH];

  assign in_range = ({1'b0, ADDR_} < DEPTH_W);
  // A CLR_MEM request wins over a same-cycle access, which is dropped.
  assign accept   = (state == IDLE) && !CLR_MEM && EN_;
  assign busy     = (state == CLEAR);

  always_ff @(posedge CLK_) begin
    if (CLR) begin
      state <= CLEAR;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    mem_we    = 1'b0;
    mem_wa    = ADDR_;
    mem_wd    = data_in;
    case (state)
      IDLE: begin
        if (CLR_MEM) begin
          state_nxt = CLEAR;
          ptr_nxt   = '0;
        end else if (EN_ && R_W_ && in_range) begin
          mem_we = 1'b1;
        end
      end
      CLEAR: begin
        mem_we = 1'b1;
        mem_wa = ptr;
        mem_wd = '0;
        if (ptr == LAST) begin
          state_nxt = IDLE;
          ptr_nxt   = '0;
        end else begin
          ptr_nxt = ptr + 1'b1;
        end
      end
      default: begin
        state_nxt = CLEAR;
        ptr_nxt   = '0;
      end
    endcase
  end

  // The array itself has no reset; the sweep that follows CLR zeroes it.
  always_ff @(posedge CLK_) begin
    if (mem_we && !CLR) begin
      mem[mem_wa] <= mem_wd;
    end
  end

  always_ff @(posedge CLK_) begin
    if (CLR) begin
      data_out <= '0;
      rd_valid <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      data_out <= '0;
      rd_valid <= 1'b0;
      if (accept) begin
        if (in_range) begin
          addr_err <= 1'b0;
          if (!R_W_) begin
            data_out <= mem[ADDR_];
            rd_valid <= 1'b1;
          end
        end else begin
          addr_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ram_nxw_sync.sv
// Directed bench for ram_nxw_sync: three instances (8x4, 6x4 with out-of-range space, 32x16).
module tb_ram_nxw_sync;

  logic CLK_ = 1'b0;
  always #5 CLK_ = ~CLK_;

  logic        clr8, en8, rw8, cm8;
  logic [2:0]  addr8;
  logic [3:0]  din8, dout8;
  logic        vld8, err8, busy8;

  logic        clr6, en6, rw6, cm6;
  logic [2:0]  addr6;
  logic [3:0]  din6, dout6;
  logic        vld6, err6, busy6;

  logic        clr32, en32, rw32, cm32;
  logic [4:0]  addr32;
  logic [15:0] din32, dout32;
  logic        vld32, err32, busy32;

  ram_nxw_sync #(.WIDTH(4), .DEPTH(8), .AW(3)) u8 (
    .CLK_(CLK_), .CLR(clr8), .EN_(en8), .R_W_(rw8), .ADDR_(addr8), .data_in(din8),
    .CLR_MEM(cm8), .data_out(dout8), .rd_valid(vld8), .addr_err(err8), .busy(busy8));

  ram_nxw_sync #(.WIDTH(4), .DEPTH(6), .AW(3)) u6 (
    .CLK_(CLK_), .CLR(clr6), .EN_(en6), .R_W_(rw6), .ADDR_(addr6), .data_in(din6),
    .CLR_MEM(cm6), .data_out(dout6), .rd_valid(vld6), .addr_err(err6), .busy(busy6));

  ram_nxw_sync #(.WIDTH(16), .DEPTH(32), .AW(5)) u32 (
    .CLK_(CLK_), .CLR(clr32), .EN_(en32), .R_W_(rw32), .ADDR_(addr32), .data_in(din32),
    .CLR_MEM(cm32), .data_out(dout32), .rd_valid(vld32), .addr_err(err32), .busy(busy32));

  typedef struct {
    logic       en;
    logic       rw;
    logic [2:0] addr;
    logic [3:0] din;
    logic [3:0] exp_dout;
    logic       exp_vld;
    logic       exp_err;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK_);
    #1;
  endtask

  task automatic drv8(input logic en, input logic rw, input logic [2:0] a, input logic [3:0] d);
    en8 = en; rw8 = rw; addr8 = a; din8 = d;
  endtask

  task automatic drv6(input logic en, input logic rw, input logic [2:0] a, input logic [3:0] d);
    en6 = en; rw6 = rw; addr6 = a; din6 = d;
  endtask

  task automatic run_vec(input vec_t v, input int dev, input string nm);
    if (dev == 8) drv8(v.en, v.rw, v.addr, v.din);
    else          drv6(v.en, v.rw, v.addr, v.din);
    tick();
    if (dev == 8) begin
      chk({nm, ".dout"}, 32'(dout8), 32'(v.exp_dout));
      chk({nm, ".vld"},  32'(vld8),  32'(v.exp_vld));
      chk({nm, ".err"},  32'(err8),  32'(v.exp_err));
    end else begin
      chk({nm, ".dout"}, 32'(dout6), 32'(v.exp_dout));
      chk({nm, ".vld"},  32'(vld6),  32'(v.exp_vld));
      chk({nm, ".err"},  32'(err6),  32'(v.exp_err));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vec_t t2 [9];
    vec_t t3 [9];
    int c8, c6, c32;

    // write/readback on the 8-word instance (R_W_=1 write)
    t2[0] = '{1'b1, 1'b1, 3'd3, 4'hA, 4'h0, 1'b0, 1'b0};
    t2[1] = '{1'b1, 1'b1, 3'd7, 4'h5, 4'h0, 1'b0, 1'b0};
    t2[2] = '{1'b1, 1'b0, 3'd3, 4'h0, 4'hA, 1'b1, 1'b0};
    t2[3] = '{1'b1, 1'b0, 3'd7, 4'h0, 4'h5, 1'b1, 1'b0};
    t2[4] = '{1'b0, 1'b0, 3'd7, 4'h0, 4'h0, 1'b0, 1'b0};
    t2[5] = '{1'b1, 1'b1, 3'd3, 4'h6, 4'h0, 1'b0, 1'b0};
    t2[6] = '{1'b1, 1'b0, 3'd3, 4'h0, 4'h6, 1'b1, 1'b0};
    t2[7] = '{1'b1, 1'b0, 3'd0, 4'h0, 4'h0, 1'b1, 1'b0};
    t2[8] = '{1'b1, 1'b0, 3'd7, 4'h0, 4'h5, 1'b1, 1'b0};

    // out-of-range on the 6-word instance
    t3[0] = '{1'b1, 1'b1, 3'd0, 4'h4, 4'h0, 1'b0, 1'b0};
    t3[1] = '{1'b1, 1'b1, 3'd6, 4'hF, 4'h0, 1'b0, 1'b1};
    t3[2] = '{1'b1, 1'b0, 3'd7, 4'h0, 4'h0, 1'b0, 1'b1};
    t3[3] = '{1'b0, 1'b0, 3'd0, 4'h0, 4'h0, 1'b0, 1'b1};
    t3[4] = '{1'b1, 1'b0, 3'd0, 4'h0, 4'h4, 1'b1, 1'b0};
    t3[5] = '{1'b1, 1'b1, 3'd5, 4'h2, 4'h0, 1'b0, 1'b0};
    t3[6] = '{1'b1, 1'b1, 3'd6, 4'h1, 4'h0, 1'b0, 1'b1};
    t3[7] = '{1'b1, 1'b0, 3'd5, 4'h0, 4'h2, 1'b1, 1'b0};
    t3[8] = '{1'b1, 1'b0, 3'd6, 4'h0, 4'h0, 1'b0, 1'b1};

    clr8 = 1'b1; clr6 = 1'b1; clr32 = 1'b1;
    cm8 = 1'b0; cm6 = 1'b0; cm32 = 1'b0;
    drv8(1'b0, 1'b0, 3'd0, 4'h0);
    drv6(1'b0, 1'b0, 3'd0, 4'h0);
    en32 = 1'b0; rw32 = 1'b0; addr32 = '0; din32 = '0;

    // 1. reset, then sweep length per instance
    tick();
    chk("rst.dout", 32'(dout8), 32'h0);
    chk("rst.vld",  32'(vld8),  32'h0);
    chk("rst.err",  32'(err8),  32'h0);
    chk("rst.busy", 32'(busy8), 32'h1);
    tick();
    clr8 = 1'b0; clr6 = 1'b0; clr32 = 1'b0;
    c8 = 0; c6 = 0; c32 = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy8)  c8++;
      if (busy6)  c6++;
      if (busy32) c32++;
      tick();
    end
    chk("sweep8.len",  32'(c8),  32'd8);
    chk("sweep6.len",  32'(c6),  32'd6);
    chk("sweep32.len", 32'(c32), 32'd32);
    for (int a = 0; a < 8; a++) begin
      drv8(1'b1, 1'b0, 3'(a), 4'h0);
      tick();
      chk("init.rd.dout", 32'(dout8), 32'h0);
      chk("init.rd.vld",  32'(vld8),  32'h1);
    end

    // 2. write / readback table
    for (int i = 0; i < 9; i++) run_vec(t2[i], 8, $sformatf("wr_rd[%0d]", i));

    // 3. out-of-range table, then CLR clears addr_err
    for (int i = 0; i < 9; i++) run_vec(t3[i], 6, $sformatf("oor[%0d]", i));
    drv6(1'b0, 1'b0, 3'd0, 4'h0);
    clr6 = 1'b1;
    tick();
    clr6 = 1'b0;
    chk("oor.rst.err",  32'(err6),  32'h0);
    chk("oor.rst.busy", 32'(busy6), 32'h1);

    // 4. CLR_MEM collision with a write; writes during the sweep are ignored
    for (int a = 0; a < 8; a++) begin
      drv8(1'b1, 1'b1, 3'(a), 4'hC);
      tick();
    end
    drv8(1'b1, 1'b0, 3'd5, 4'h0);
    tick();
    chk("fill.rd5", 32'(dout8), 32'hC);
    cm8 = 1'b1;
    drv8(1'b1, 1'b1, 3'd1, 4'h3);
    tick();
    cm8 = 1'b0;
    chk("clrmem.vld", 32'(vld8), 32'h0);
    c8 = 0;
    for (int i = 0; i < 20 && busy8; i++) begin
      c8++;
      drv8(1'b1, 1'b1, 3'(7 - (i % 8)), 4'hF);
      tick();
      chk("clrmem.busy.vld", 32'(vld8), 32'h0);
    end
    chk("clrmem.len", 32'(c8), 32'd8);
    for (int a = 0; a < 8; a++) begin
      drv8(1'b1, 1'b0, 3'(a), 4'h0);
      tick();
      chk("clrmem.rd.dout", 32'(dout8), 32'h0);
      chk("clrmem.rd.vld",  32'(vld8),  32'h1);
    end

    // 5. CLR on the fourth sweep cycle restarts the sweep
    drv8(1'b1, 1'b1, 3'd7, 4'h9);
    tick();
    drv8(1'b0, 1'b0, 3'd0, 4'h0);
    cm8 = 1'b1;
    tick();
    cm8 = 1'b0;
    tick(); tick(); tick();
    chk("midrst.pre.busy", 32'(busy8), 32'h1);
    clr8 = 1'b1;
    tick();
    clr8 = 1'b0;
    c8 = 0;
    for (int i = 0; i < 20 && busy8; i++) begin
      c8++;
      tick();
    end
    chk("midrst.len", 32'(c8), 32'd8);
    drv8(1'b1, 1'b0, 3'd7, 4'h0);
    tick();
    chk("midrst.rd7", 32'(dout8), 32'h0);
    drv8(1'b0, 1'b0, 3'd0, 4'h0);

    // 6. 32 x 16 instance: full write then full readback
    for (int k = 0; k < 32; k++) begin
      en32 = 1'b1; rw32 = 1'b1; addr32 = 5'(k); din32 = 16'h1000 + 16'(k);
      tick();
    end
    for (int k = 0; k < 32; k++) begin
      en32 = 1'b1; rw32 = 1'b0; addr32 = 5'(k);
      tick();
      chk($sformatf("w32.rd[%0d]", k), 32'(dout32), 32'h1000 + 32'(k));
      chk("w32.vld", 32'(vld32), 32'h1);
    end
    en32 = 1'b0;
    tick();
    chk("w32.idle.vld", 32'(vld32), 32'h0);
    chk("w32.err",      32'(err32), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
